// File: rtl/scatter_coinc_trig.sv
// scatter_coinc_trig: front/back scintillator-bar coincidence trigger with per-channel pulse stretch,
// one-shot output FSM and saturating trigger counter. Optional: SCATTER_TRIG_PRESCALE_EN.
//
//   state | meaning
//   IDLE  | waiting for a rising coincidence edge
//   FIRE  | trig_out_o high for the loaded output width
//   DEAD  | veto window after trig_out_o falls
module scatter_coinc_trig #(
  parameter int N_FRONT     = 18,
  parameter int N_BACK      = 28,
  parameter int GROUP       = 3,
  parameter int MAX_STRETCH = 8,
  parameter int OUT_W       = 8,
  parameter int CNT_W       = 32,
  localparam int SW         = $clog2(MAX_STRETCH + 1)
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [N_FRONT-1:0] front_in_i,
  input  logic [N_BACK-1:0]  back_in_i,
  input  logic [N_FRONT-1:0] front_mask_i,
  input  logic               enable_i,
  input  logic [SW-1:0]      cfg_stretch_i,
  input  logic [OUT_W-1:0]   cfg_out_width_i,
  input  logic [OUT_W-1:0]   cfg_deadtime_i,
`ifdef SCATTER_TRIG_PRESCALE_EN
  input  logic [7:0]         cfg_prescale_i,
`endif
  input  logic               cnt_clr_i,
  output logic               trig_out_o,
  output logic [N_FRONT-1:0] trig_hit_o,
  output logic [CNT_W-1:0]   trig_count_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {IDLE, FIRE, DEAD} state_t;

  state_t             state_q, state_d;
  logic [N_FRONT-1:0] front_q, coinc_q, coinc_d, hit_q, hit_d, fstr;
  logic [N_BACK-1:0]  back_q, bstr;
  logic [SW-1:0]      fcnt_q [N_FRONT];
  logic [SW-1:0]      fcnt_d [N_FRONT];
  logic [SW-1:0]      bcnt_q [N_BACK];
  logic [SW-1:0]      bcnt_d [N_BACK];
  logic [SW-1:0]      str_len;
  logic [OUT_W-1:0]   tcnt_q, tcnt_d, out_len;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               any, any_q, trig_cond, fire;
`ifdef SCATTER_TRIG_PRESCALE_EN
  logic [7:0]         ps_cnt_q, ps_cnt_d;
`endif

  always_comb begin
    if (cfg_stretch_i == '0)                    str_len = SW'(1);
    else if (cfg_stretch_i > SW'(MAX_STRETCH))  str_len = SW'(MAX_STRETCH);
    else                                        str_len = cfg_stretch_i;
    out_len = (cfg_out_width_i == '0) ? OUT_W'(1) : cfg_out_width_i;
  end

  // A rise reloads the counter even mid-stretch; a held level only rises once.
  always_comb begin
    for (int i = 0; i < N_FRONT; i++) begin
      fcnt_d[i] = fcnt_q[i];
      if (front_in_i[i] && !front_q[i]) fcnt_d[i] = str_len;
      else if (fcnt_q[i] != '0)         fcnt_d[i] = fcnt_q[i] - SW'(1);
      fstr[i] = (fcnt_q[i] != '0);
    end
    for (int j = 0; j < N_BACK; j++) begin
      bcnt_d[j] = bcnt_q[j];
      if (back_in_i[j] && !back_q[j]) bcnt_d[j] = str_len;
      else if (bcnt_q[j] != '0)       bcnt_d[j] = bcnt_q[j] - SW'(1);
      bstr[j] = (bcnt_q[j] != '0);
    end
  end

  // Back group for front bar i starts at i*N_BACK/N_FRONT; the j<N_BACK bound clips the top end.
  always_comb begin
    logic grp;
    grp     = 1'b0;
    coinc_d = '0;
    for (int i = 0; i < N_FRONT; i++) begin
      grp = 1'b0;
      for (int j = 0; j < N_BACK; j++) begin
        if (j >= (i * N_BACK) / N_FRONT && j < (i * N_BACK) / N_FRONT + GROUP)
          grp = grp | bstr[j];
      end
      coinc_d[i] = fstr[i] & front_mask_i[i] & grp;
    end
  end

  assign any       = |coinc_q;
  assign trig_cond = any & ~any_q & enable_i & (state_q == IDLE);

`ifdef SCATTER_TRIG_PRESCALE_EN
  always_comb begin
    fire     = 1'b0;
    ps_cnt_d = ps_cnt_q;
    if (trig_cond) begin
      if (ps_cnt_q == cfg_prescale_i) begin
        fire     = 1'b1;
        ps_cnt_d = '0;
      end else begin
        ps_cnt_d = ps_cnt_q + 8'd1;
      end
    end
  end
`else
  assign fire = trig_cond;
`endif

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    hit_d   = hit_q;
    case (state_q)
      IDLE: begin
        if (fire) begin
          state_d = FIRE;
          tcnt_d  = out_len;
          hit_d   = coinc_q;
        end
      end
      FIRE: begin
        if (tcnt_q <= OUT_W'(1)) begin
          if (cfg_deadtime_i != '0) begin
            state_d = DEAD;
            tcnt_d  = cfg_deadtime_i;
          end else begin
            state_d = IDLE;
            tcnt_d  = '0;
          end
        end else begin
          tcnt_d = tcnt_q - OUT_W'(1);
        end
      end
      DEAD: begin
        if (tcnt_q <= OUT_W'(1)) begin
          state_d = IDLE;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q - OUT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Every trigger condition counts; a clear in the same cycle keeps that one count.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i)                cnt_d = CNT_W'(trig_cond);
    else if (trig_cond && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      front_q  <= '0;
      back_q   <= '0;
      coinc_q  <= '0;
      any_q    <= 1'b0;
      state_q  <= IDLE;
      tcnt_q   <= '0;
      hit_q    <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < N_FRONT; i++) fcnt_q[i] <= '0;
      for (int j = 0; j < N_BACK; j++)  bcnt_q[j] <= '0;
`ifdef SCATTER_TRIG_PRESCALE_EN
      ps_cnt_q <= '0;
`endif
    end else begin
      front_q  <= front_in_i;
      back_q   <= back_in_i;
      coinc_q  <= coinc_d;
      any_q    <= any;
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
      hit_q    <= hit_d;
      cnt_q    <= cnt_d;
      for (int i = 0; i < N_FRONT; i++) fcnt_q[i] <= fcnt_d[i];
      for (int j = 0; j < N_BACK; j++)  bcnt_q[j] <= bcnt_d[j];
`ifdef SCATTER_TRIG_PRESCALE_EN
      ps_cnt_q <= ps_cnt_d;
`endif
    end
  end

  assign trig_out_o   = (state_q == FIRE);
  assign busy_o       = (state_q != IDLE);
  assign trig_hit_o   = hit_q;
  assign trig_count_o = cnt_q;

endmodule
